// File: rtl/stream_wr_scheduler.sv
// stream_wr_scheduler
// Turns an incoming video stream into a sequence of AXI write bursts.
// Bursts are issued line by line across a ring of BUF_NUM frame buffers.
// Each burst is at most BURST_LEN beats and is issued only once the line
// FIFO holds enough beats for the whole burst.
// A frame-start pulse (falign) that arrives mid-frame restarts the frame
// at line 0 of the same buffer and raises a one-cycle resync pulse.
// Optional build macro: STREAM_WR_ERR_CNT_EN. When it is defined, err_cnt
// counts resync pulses and saturates at 16'hFFFF. When it is undefined,
// err_cnt is tied to 0.
module stream_wr_scheduler #(
    parameter int ADDR_W    = 32,
    parameter int BURST_LEN = 64,
    parameter int BPB       = 4,
    parameter int BUF_NUM   = 3
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic [15:0]       hactive,
    input  logic [15:0]       vactive,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] frame_stride,
    input  logic [15:0]       line_stride,
    input  logic              falign,
    input  logic [15:0]       fifo_count,
    output logic              burst_req,
    input  logic              burst_ack,
    input  logic              burst_done,
    output logic [ADDR_W-1:0] burst_addr,
    output logic [7:0]        burst_len,
    output logic [1:0]        buf_index,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              resync,
    output logic [15:0]       err_cnt
);

    localparam logic [15:0]       LP_BL16     = 16'(BURST_LEN);
    localparam logic [8:0]        LP_BL9      = 9'(BURST_LEN);
    localparam logic [ADDR_W-1:0] LP_BPB      = ADDR_W'(BPB);
    localparam logic [1:0]        LP_BUF_LAST = 2'(BUF_NUM - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOF = 3'd1,
        ST_ARM      = 3'd2,
        ST_REQ      = 3'd3,
        ST_BUSY     = 3'd4,
        ST_NEXT     = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Frame geometry latched at frame start
    logic [15:0]       r_hact;
    logic [15:0]       r_vact;
    logic [15:0]       r_lstride;
    logic [ADDR_W-1:0] r_fbase;

    // Walking position inside the frame
    logic [ADDR_W-1:0] r_line_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_beat_cnt;
    logic [15:0]       r_line_cnt;
    logic [8:0]        r_cur_len;

    // Control and output registers
    logic              r_pend;
    logic [1:0]        r_buf_idx;
    logic              r_resync;
    logic              r_frame_done;
    logic [ADDR_W-1:0] r_burst_addr;
    logic [7:0]        r_burst_len;

    // Combinational helpers
    logic [15:0]       w_rem;
    logic [8:0]        w_len;
    logic [15:0]       w_beat_nxt;
    logic              w_line_end;
    logic              w_frame_last;
    logic [1:0]        w_buf_nxt;
    logic [ADDR_W-1:0] w_base_cur;
    logic [ADDR_W-1:0] w_base_nxt;
    logic [ADDR_W-1:0] w_base_sel;
    logic [ADDR_W-1:0] w_burst_bytes;

    // FSM strobes
    logic w_start;
    logic w_start_nxt_buf;
    logic w_restart;
    logic w_issue;
    logic w_advance;
    logic w_fdone;
    logic w_resync;
    logic w_pend_set;

    assign w_rem         = r_hact - r_beat_cnt;
    assign w_len         = (w_rem > LP_BL16) ? LP_BL9 : w_rem[8:0];
    assign w_beat_nxt    = r_beat_cnt + {7'd0, r_cur_len};
    assign w_line_end    = (w_beat_nxt >= r_hact);
    assign w_frame_last  = w_line_end && ((r_line_cnt + 16'd1) >= r_vact);
    assign w_buf_nxt     = (r_buf_idx >= LP_BUF_LAST) ? 2'd0 : r_buf_idx + 2'd1;
    // Buffer addresses wrap modulo 2^ADDR_W by construction
    assign w_base_cur    = base_addr + ADDR_W'(r_buf_idx) * frame_stride;
    assign w_base_nxt    = base_addr + ADDR_W'(w_buf_nxt) * frame_stride;
    assign w_base_sel    = w_start_nxt_buf ? w_base_nxt : w_base_cur;
    assign w_burst_bytes = ADDR_W'(r_cur_len) * LP_BPB;

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and the datapath strobes that go with each transition
    always_comb begin
        w_state_nxt     = r_state;
        w_start         = 1'b0;
        w_start_nxt_buf = 1'b0;
        w_restart       = 1'b0;
        w_issue         = 1'b0;
        w_advance       = 1'b0;
        w_fdone         = 1'b0;
        w_resync        = 1'b0;
        w_pend_set      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (falign) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                // A frame start while no burst is in flight restarts immediately
                if (falign) begin
                    w_resync  = 1'b1;
                    w_restart = 1'b1;
                end else if (fifo_count >= {7'd0, w_len}) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (falign) begin
                    w_resync   = 1'b1;
                    w_pend_set = 1'b1;
                end
                if (burst_ack) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (falign) begin
                    w_resync   = 1'b1;
                    w_pend_set = 1'b1;
                end
                if (burst_done) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (r_pend || (falign && !w_frame_last)) begin
                    // Interrupted frame: back to line 0 of the same buffer
                    w_resync    = falign;
                    w_restart   = 1'b1;
                    w_state_nxt = ST_ARM;
                end else if (w_frame_last) begin
                    w_fdone = 1'b1;
                    if (falign) begin
                        // Frame start coincides with frame end: begin the next frame now
                        w_start         = 1'b1;
                        w_start_nxt_buf = 1'b1;
                        w_state_nxt     = ST_ARM;
                    end else if (enable) begin
                        w_state_nxt = ST_WAIT_SOF;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_advance   = 1'b1;
                    w_state_nxt = ST_ARM;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counters, pending flag, buffer index and registered outputs
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_beat_cnt   <= 16'd0;
            r_line_cnt   <= 16'd0;
            r_pend       <= 1'b0;
            r_buf_idx    <= 2'd0;
            r_resync     <= 1'b0;
            r_frame_done <= 1'b0;
            r_burst_addr <= '0;
            r_burst_len  <= 8'd0;
        end else begin
            r_resync     <= w_resync;
            r_frame_done <= w_fdone;
            if (w_pend_set) begin
                r_pend <= 1'b1;
            end else if (w_restart) begin
                r_pend <= 1'b0;
            end
            if (w_start || w_restart) begin
                r_beat_cnt <= 16'd0;
                r_line_cnt <= 16'd0;
            end else if (w_advance) begin
                if (w_line_end) begin
                    r_beat_cnt <= 16'd0;
                    r_line_cnt <= r_line_cnt + 16'd1;
                end else begin
                    r_beat_cnt <= w_beat_nxt;
                end
            end
            if (w_issue) begin
                r_burst_addr <= r_addr;
                r_burst_len  <= 8'(w_len - 9'd1);
            end
            if (w_fdone) begin
                r_buf_idx <= w_buf_nxt;
            end
        end
    end

    // Frame geometry and address walk; always reloaded before use, so no reset
    always_ff @(posedge aclk) begin
        if (w_start) begin
            r_hact      <= hactive;
            r_vact      <= vactive;
            r_lstride   <= line_stride;
            r_fbase     <= w_base_sel;
            r_line_addr <= w_base_sel;
            r_addr      <= w_base_sel;
        end else if (w_restart) begin
            r_line_addr <= r_fbase;
            r_addr      <= r_fbase;
        end else if (w_advance) begin
            if (w_line_end) begin
                r_line_addr <= r_line_addr + ADDR_W'(r_lstride);
                r_addr      <= r_line_addr + ADDR_W'(r_lstride);
            end else begin
                r_addr <= r_addr + w_burst_bytes;
            end
        end
        if (w_issue) begin
            r_cur_len <= w_len;
        end
    end

`ifdef STREAM_WR_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Saturating count of resync events
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_err_cnt <= 16'd0;
        end else if (w_resync && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 16'd0;
`endif

    assign burst_req  = (r_state == ST_REQ);
    assign frame_busy = (r_state == ST_ARM) || (r_state == ST_REQ) ||
                        (r_state == ST_BUSY) || (r_state == ST_NEXT);
    assign burst_addr = r_burst_addr;
    assign burst_len  = r_burst_len;
    assign buf_index  = r_buf_idx;
    assign frame_done = r_frame_done;
    assign resync     = r_resync;

endmodule

// File: tb/tb_stream_wr_scheduler.sv
// tb_stream_wr_scheduler
// Plays the AXI write master with random ack/done latencies.
// Every burst is compared against a burst list built from the frame geometry.
`timescale 1ns/1ps
module tb_stream_wr_scheduler;

    localparam int ADDR_W    = 32;
    localparam int BURST_LEN = 64;
    localparam int BPB       = 4;
    localparam int BUF_NUM   = 3;

`ifdef STREAM_WR_ERR_CNT_EN
    localparam int ERR_EXP = 1;
`else
    localparam int ERR_EXP = 0;
`endif

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              enable = 1'b0;
    logic [15:0]       hactive = 16'd1;
    logic [15:0]       vactive = 16'd1;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] frame_stride = '0;
    logic [15:0]       line_stride = 16'd0;
    logic              falign = 1'b0;
    logic [15:0]       fifo_count = 16'hFFFF;
    logic              burst_req;
    logic              burst_ack = 1'b0;
    logic              burst_done = 1'b0;
    logic [ADDR_W-1:0] burst_addr;
    logic [7:0]        burst_len;
    logic [1:0]        buf_index;
    logic              frame_busy;
    logic              frame_done;
    logic              resync;
    logic [15:0]       err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_cnt  = 0;
    int rs_cnt  = 0;
    int m_buf   = 0;
    logic [31:0] q_addr[$];
    int          q_len[$];

    stream_wr_scheduler #(
        .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .BPB(BPB), .BUF_NUM(BUF_NUM)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .hactive(hactive), .vactive(vactive), .base_addr(base_addr),
        .frame_stride(frame_stride), .line_stride(line_stride),
        .falign(falign), .fifo_count(fifo_count),
        .burst_req(burst_req), .burst_ack(burst_ack), .burst_done(burst_done),
        .burst_addr(burst_addr), .burst_len(burst_len), .buf_index(buf_index),
        .frame_busy(frame_busy), .frame_done(frame_done), .resync(resync),
        .err_cnt(err_cnt)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (frame_done) fd_cnt++;
        if (resync) rs_cnt++;
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        enable  = 1'b1;
        falign  = 1'b0;
        burst_ack = 1'b0;
        burst_done = 1'b0;
        fifo_count = 16'hFFFF;
        tick(2);
        aresetn = 1'b1;
        m_buf = 0;
        tick(2);
    endtask

    // Reference burst list for one frame: lines split into BURST_LEN chunks
    task automatic model_frame(input int hact, input int vact, input logic [31:0] base,
                               input logic [31:0] fstr, input int lstr);
        logic [31:0] fb;
        int          off;
        fb = base + m_buf * fstr;
        for (int l = 0; l < vact; l++) begin
            off = 0;
            while (off < hact) begin
                q_addr.push_back(fb + l * lstr + off * BPB);
                q_len.push_back((hact - off > BURST_LEN) ? BURST_LEN : hact - off);
                off += BURST_LEN;
            end
        end
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!burst_req && n < 2000) begin
            tick(1);
            n++;
        end
        check(tag, burst_req, 1);
    endtask

    task automatic serve_burst(input logic [31:0] ea, input int el, input int ack_dly, input int done_dly);
        wait_req("req_seen");
        check("burst_addr", burst_addr, ea);
        check("burst_len", burst_len, el - 1);
        check("frame_busy", frame_busy, 1);
        for (int i = 0; i < ack_dly; i++) begin
            tick(1);
            check("req_hold", burst_req, 1);
            check("addr_hold", burst_addr, ea);
            check("len_hold", burst_len, el - 1);
        end
        burst_ack = 1'b1;
        tick(1);
        burst_ack = 1'b0;
        check("req_drop", burst_req, 0);
        tick(done_dly);
        burst_done = 1'b1;
        tick(1);
        burst_done = 1'b0;
    endtask

    task automatic set_geom(input int hact, input int vact, input logic [31:0] base,
                            input logic [31:0] fstr, input int lstr);
        hactive      = 16'(hact);
        vactive      = 16'(vact);
        base_addr    = base;
        frame_stride = fstr;
        line_stride  = 16'(lstr);
    endtask

    task automatic run_frame(input int hact, input int vact, input logic [31:0] base,
                             input logic [31:0] fstr, input int lstr, input int maxdly);
        int          fd0;
        logic [31:0] a;
        int          l;
        set_geom(hact, vact, base, fstr, lstr);
        q_addr.delete();
        q_len.delete();
        model_frame(hact, vact, base, fstr, lstr);
        check("buf_index_start", buf_index, m_buf);
        fd0 = fd_cnt;
        falign = 1'b1;
        tick(1);
        falign = 1'b0;
        while (q_addr.size() > 0) begin
            a = q_addr.pop_front();
            l = q_len.pop_front();
            serve_burst(a, l, int'($urandom_range(maxdly)), int'($urandom_range(maxdly)));
        end
        tick(4);
        check("frame_done_cnt", fd_cnt - fd0, 1);
        m_buf = (m_buf + 1) % BUF_NUM;
        check("buf_index_next", buf_index, m_buf);
    endtask

    initial begin
        int          fd0;
        logic [31:0] a;
        int          l;

        // Reset state
        do_reset();
        check("rst_req", burst_req, 0);
        check("rst_addr", burst_addr, 0);
        check("rst_len", burst_len, 0);
        check("rst_buf", buf_index, 0);
        check("rst_busy", frame_busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_resync", resync, 0);
        check("rst_err", err_cnt, 0);

        // Two 100-beat lines split 64+36
        run_frame(100, 2, 32'h1000, 32'h10000, 32'h200, 3);

        // FIFO gating and a delayed ack
        do_reset();
        set_geom(64, 1, 32'h2000, 32'h10000, 32'h100);
        q_addr.delete();
        q_len.delete();
        model_frame(64, 1, 32'h2000, 32'h10000, 32'h100);
        fifo_count = 16'd10;
        fd0 = fd_cnt;
        falign = 1'b1;
        tick(1);
        falign = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("req_low_fifo", burst_req, 0);
        end
        fifo_count = 16'd64;
        tick(1);
        check("req_after_fifo", burst_req, 1);
        serve_burst(q_addr.pop_front(), q_len.pop_front(), 5, 2);
        tick(4);
        check("frame_done_gate", fd_cnt - fd0, 1);
        m_buf = (m_buf + 1) % BUF_NUM;
        fifo_count = 16'hFFFF;

        // Buffer ring 0,1,2,0
        do_reset();
        for (int f = 0; f < 4; f++) begin
            run_frame(8, 1, 32'h4000, 32'h10000, 32'h40, 2);
        end

        // Random geometry
        for (int f = 0; f < 6; f++) begin
            run_frame(int'($urandom_range(200, 1)), int'($urandom_range(3, 1)), $urandom & 32'hFFFF_FFFC,
                      $urandom & 32'hFFFF_FFFC, int'($urandom_range(16'h3FFF)) * 4, 4);
        end

        // falign during BUSY on line 1
        do_reset();
        set_geom(100, 2, 32'h1000, 32'h10000, 32'h200);
        q_addr.delete();
        q_len.delete();
        model_frame(100, 2, 32'h1000, 32'h10000, 32'h200);
        fd0 = fd_cnt;
        falign = 1'b1;
        tick(1);
        falign = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = q_addr.pop_front();
            l = q_len.pop_front();
            serve_burst(a, l, 1, 1);
        end
        wait_req("req_line1");
        check("addr_line1", burst_addr, 32'h1200);
        burst_ack = 1'b1;
        tick(1);
        burst_ack = 1'b0;
        tick(1);
        falign = 1'b1;
        tick(1);
        falign = 1'b0;
        check("resync_pulse", resync, 1);
        tick(1);
        check("resync_drop", resync, 0);
        check("busy_in_flight", frame_busy, 1);
        burst_done = 1'b1;
        tick(1);
        burst_done = 1'b0;
        tick(3);
        check("no_frame_done", fd_cnt - fd0, 0);
        check("err_cnt", err_cnt, ERR_EXP);
        check("buf_same", buf_index, 0);
        q_addr.delete();
        q_len.delete();
        model_frame(100, 2, 32'h1000, 32'h10000, 32'h200);
        while (q_addr.size() > 0) begin
            a = q_addr.pop_front();
            l = q_len.pop_front();
            serve_burst(a, l, int'($urandom_range(2)), int'($urandom_range(2)));
        end
        tick(4);
        check("frame_done_after_restart", fd_cnt - fd0, 1);
        m_buf = (m_buf + 1) % BUF_NUM;

        // Reset while BUSY
        set_geom(100, 2, 32'h1000, 32'h10000, 32'h200);
        fd0 = fd_cnt;
        falign = 1'b1;
        tick(1);
        falign = 1'b0;
        wait_req("req_pre_rst");
        burst_ack = 1'b1;
        tick(1);
        burst_ack = 1'b0;
        tick(1);
        aresetn = 1'b0;
        tick(1);
        aresetn = 1'b1;
        check("brst_req", burst_req, 0);
        check("brst_addr", burst_addr, 0);
        check("brst_len", burst_len, 0);
        check("brst_buf", buf_index, 0);
        check("brst_busy", frame_busy, 0);
        check("brst_done", frame_done, 0);
        check("brst_resync", resync, 0);
        check("brst_err", err_cnt, 0);
        m_buf = 0;
        tick(2);
        burst_done = 1'b1;
        tick(1);
        burst_done = 1'b0;
        tick(3);
        check("late_done_req", burst_req, 0);
        check("late_done_busy", frame_busy, 0);
        check("late_done_fd", fd_cnt - fd0, 0);
        run_frame(100, 2, 32'h1000, 32'h10000, 32'h200, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
